// File: rtl/animation_scheduler.sv
// Game-level sequencer: arbitrates goal/win/pause events into the LED
// animation mode, times each animation in ball ticks and gates ball motion.
module animation_scheduler #(
    parameter int unsigned GOAL_TICKS = 24,
    parameter int unsigned WIN_TICKS  = 12,
    parameter int unsigned CNT_W      = 8
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       tick,
    input  logic       goal_req,
    input  logic       win_req,
    input  logic       pause_toggle,
    output logic [1:0] mode,
    output logic       anim_start,
    output logic       game_run,
    output logic       busy,
    output logic       restart
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAUSE,
        S_GOAL,
        S_WIN,
        S_OVER
    } state_e;

    localparam logic [CNT_W-1:0] GOAL_LAST = CNT_W'(GOAL_TICKS - 1);
    localparam logic [CNT_W-1:0] WIN_LAST  = CNT_W'(WIN_TICKS - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             goal_pend_q, goal_pend_d;
    logic [1:0]       mode_q, mode_d;
    logic             anim_start_q, anim_start_d;
    logic             game_run_q, game_run_d;
    logic             busy_q, busy_d;
    logic             restart_q, restart_d;
    logic             enter_anim;
    logic             pend_now;

    // Next state, counter and registered outputs derived from the next state.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        goal_pend_d = goal_pend_q;
        enter_anim  = 1'b0;
        restart_d   = 1'b0;
        pend_now    = goal_pend_q | goal_req;

        unique case (state_q)
            S_IDLE: begin
                if (win_req) begin
                    state_d    = S_WIN;
                    cnt_d      = '0;
                    enter_anim = 1'b1;
                end else if (goal_req) begin
                    state_d    = S_GOAL;
                    cnt_d      = '0;
                    enter_anim = 1'b1;
                end else if (pause_toggle) begin
                    state_d    = S_PAUSE;
                    cnt_d      = '0;
                    enter_anim = 1'b1;
                end
            end
            S_GOAL: begin
                if (win_req) begin
                    state_d     = S_WIN;
                    cnt_d       = '0;
                    goal_pend_d = 1'b0;
                    enter_anim  = 1'b1;
                end else begin
                    // A goal in the same cycle as the last tick still re-arms.
                    if (goal_req) goal_pend_d = 1'b1;
                    if (tick) begin
                        if (cnt_q == GOAL_LAST) begin
                            cnt_d = '0;
                            if (pend_now) begin
                                goal_pend_d = 1'b0;
                                enter_anim  = 1'b1;
                            end else begin
                                state_d = S_IDLE;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            S_WIN: begin
                if (tick) begin
                    if (cnt_q == WIN_LAST) begin
                        state_d = S_OVER;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            S_OVER: begin
                if (pause_toggle) begin
                    state_d   = S_IDLE;
                    restart_d = 1'b1;
                end
            end
            S_PAUSE: begin
                if (pause_toggle) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        unique case (state_d)
            S_PAUSE: mode_d = 2'b01;
            S_GOAL:  mode_d = 2'b10;
            S_WIN:   mode_d = 2'b11;
            default: mode_d = 2'b00;
        endcase

        // Back-to-back entries collapse to a single start pulse.
        anim_start_d = enter_anim & ~anim_start_q;
        game_run_d   = (state_d == S_IDLE);
        busy_d       = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            goal_pend_q  <= 1'b0;
            mode_q       <= 2'b00;
            anim_start_q <= 1'b0;
            game_run_q   <= 1'b1;
            busy_q       <= 1'b0;
            restart_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            goal_pend_q  <= goal_pend_d;
            mode_q       <= mode_d;
            anim_start_q <= anim_start_d;
            game_run_q   <= game_run_d;
            busy_q       <= busy_d;
            restart_q    <= restart_d;
        end
    end

    assign mode       = mode_q;
    assign anim_start = anim_start_q;
    assign game_run   = game_run_q;
    assign busy       = busy_q;
    assign restart    = restart_q;

endmodule

// File: tb/tb_animation_scheduler.sv
// Directed self-checking bench for animation_scheduler.
module tb_animation_scheduler;

    logic       CLOCK;
    logic       RESET_N;
    logic       tick;
    logic       goal_req;
    logic       win_req;
    logic       pause_toggle;
    logic [1:0] mode;
    logic       anim_start;
    logic       game_run;
    logic       busy;
    logic       restart;

    int checks = 0;
    int errors = 0;
    int starts = 0;

    animation_scheduler dut (
        .CLOCK        (CLOCK),
        .RESET_N      (RESET_N),
        .tick         (tick),
        .goal_req     (goal_req),
        .win_req      (win_req),
        .pause_toggle (pause_toggle),
        .mode         (mode),
        .anim_start   (anim_start),
        .game_run     (game_run),
        .busy         (busy),
        .restart      (restart)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, return 1 ns after the edge with inputs cleared.
    task automatic drive(input logic t, input logic g, input logic w, input logic p);
        tick = t; goal_req = g; win_req = w; pause_toggle = p;
        @(posedge CLOCK);
        #1;
        tick = 1'b0; goal_req = 1'b0; win_req = 1'b0; pause_toggle = 1'b0;
        if (anim_start === 1'b1) starts++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mode"},    8'(mode),       8'd0);
        chk({tag, "_run"},     8'(game_run),   8'd1);
        chk({tag, "_busy"},    8'(busy),       8'd0);
        chk({tag, "_start"},   8'(anim_start), 8'd0);
        chk({tag, "_restart"}, 8'(restart),    8'd0);
    endtask

    initial begin
        tick = 1'b0; goal_req = 1'b0; win_req = 1'b0; pause_toggle = 1'b0;
        RESET_N = 1'b0;
        #23;
        chk_reset_vals("rst");
        RESET_N = 1'b1;
        @(posedge CLOCK); #1;

        // 1: single goal animation
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s1_mode",  8'(mode),       8'd2);
        chk("s1_start", 8'(anim_start), 8'd1);
        chk("s1_run",   8'(game_run),   8'd0);
        chk("s1_busy",  8'(busy),       8'd1);
        ticks(23);
        chk("s1_hold_mode",  8'(mode),       8'd2);
        chk("s1_hold_start", 8'(anim_start), 8'd0);
        ticks(1);
        chk("s1_end_mode", 8'(mode),     8'd0);
        chk("s1_end_run",  8'(game_run), 8'd1);
        chk("s1_end_busy", 8'(busy),     8'd0);

        // 2: pending goal, second request dropped
        starts = 0;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(5);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(2);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(16);
        chk("s2_pre_mode", 8'(mode), 8'd2);
        ticks(1);
        chk("s2_re_mode",  8'(mode),       8'd2);
        chk("s2_re_start", 8'(anim_start), 8'd1);
        ticks(23);
        chk("s2_hold_mode", 8'(mode), 8'd2);
        ticks(1);
        chk("s2_end_mode", 8'(mode),     8'd0);
        chk("s2_end_run",  8'(game_run), 8'd1);
        chk("s2_starts",   8'(starts),   8'd2);

        // 3: win beats goal, over, restart
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        chk("s3_mode",  8'(mode),       8'd3);
        chk("s3_start", 8'(anim_start), 8'd1);
        ticks(11);
        chk("s3_hold_mode", 8'(mode), 8'd3);
        ticks(1);
        chk("s3_over_mode",  8'(mode),       8'd0);
        chk("s3_over_run",   8'(game_run),   8'd0);
        chk("s3_over_busy",  8'(busy),       8'd1);
        chk("s3_over_start", 8'(anim_start), 8'd0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("s3_over_ign_mode", 8'(mode),     8'd0);
        chk("s3_over_ign_run",  8'(game_run), 8'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s3_restart", 8'(restart),  8'd1);
        chk("s3_run",     8'(game_run), 8'd1);
        chk("s3_busy",    8'(busy),     8'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        chk("s3_restart_end", 8'(restart), 8'd0);

        // 4: pause freezes everything
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s4_mode",  8'(mode),       8'd1);
        chk("s4_run",   8'(game_run),   8'd0);
        chk("s4_start", 8'(anim_start), 8'd1);
        for (int i = 0; i < 50; i++) drive(1'b1, 1'b1, 1'b1, 1'b0);
        chk("s4_hold_mode", 8'(mode),     8'd1);
        chk("s4_hold_run",  8'(game_run), 8'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s4_end_mode",  8'(mode),       8'd0);
        chk("s4_end_run",   8'(game_run),   8'd1);
        chk("s4_end_start", 8'(anim_start), 8'd0);

        // 5: win preempts goal, tick in the same cycle not counted
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        ticks(10);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        chk("s5_mode",  8'(mode),       8'd3);
        chk("s5_start", 8'(anim_start), 8'd1);
        ticks(11);
        chk("s5_hold_mode", 8'(mode), 8'd3);
        ticks(1);
        chk("s5_over_mode", 8'(mode),     8'd0);
        chk("s5_over_run",  8'(game_run), 8'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        chk("s5_restart", 8'(restart), 8'd1);

        // 6: async reset mid-win
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        ticks(3);
        chk("s6_pre_mode", 8'(mode), 8'd3);
        #2 RESET_N = 1'b0;
        #1;
        chk_reset_vals("s6_async");
        @(posedge CLOCK); #1;
        RESET_N = 1'b1;
        chk_reset_vals("s6_after");
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        chk("s6_goal_mode",  8'(mode),       8'd2);
        chk("s6_goal_start", 8'(anim_start), 8'd1);
        ticks(23);
        chk("s6_hold_mode", 8'(mode), 8'd2);
        ticks(1);
        chk("s6_end_mode", 8'(mode),     8'd0);
        chk("s6_end_run",  8'(game_run), 8'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
